// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Branch-condition encodings and writeback bundle sizing.
package mips_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LTZ  = 2'b11
  } br_type_e;

  // valid + reg_write + mem_to_reg; wr_reg is added by the user
  localparam int WB_CTRL_W = 3;

  function automatic logic br_cond(
    input br_type_e t,
    input logic     zero,
    input logic     neg
  );
    logic c;
    c = 1'b0;
    unique case (t)
      BR_NONE: c = 1'b0;
      BR_EQ:   c = zero;
      BR_NE:   c = !zero;
      BR_LTZ:  c = neg;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Stall-aware shift register carrying the writeback bundle.
// Ports: clk, rst (sync, high), stall (hold), d in, q out (last stage).
module wb_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else if (!stall) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mem_branch_resolve_stage.sv
// MEM-stage branch resolution, flush generation and WB control delay.
// In: clk, rst, stall, in_valid, branch_type, zero, alu_neg,
//   branch_target, wr_reg_in, reg_write_in, mem_to_reg_in.
// Out: pc_src, pc_target, flush, wb_valid, wr_reg_out,
//   reg_write_out, mem_to_reg_out.
module mem_branch_resolve_stage
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int ADDR_W       = 32,
  parameter int WB_DELAY     = 1,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [1:0]            branch_type,
  input  logic                  zero,
  input  logic                  alu_neg,
  input  logic [ADDR_W-1:0]     branch_target,
  input  logic [REG_ADDR_W-1:0] wr_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  output logic                  pc_src,
  output logic [ADDR_W-1:0]     pc_target,
  output logic                  flush,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wr_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int BW = WB_CTRL_W + REG_ADDR_W;

  logic [CW-1:0] flush_cnt;
  logic          cond;
  logic          live;
  logic          taken;
  logic          squash;
  logic [BW-1:0] wb_d;
  logic [BW-1:0] wb_q;

  assign cond   = br_cond(br_type_e'(branch_type), zero, alu_neg);
  assign live   = in_valid && !stall && (flush_cnt == '0);
  assign taken  = live && cond;
  assign flush  = (flush_cnt != '0);
  assign squash = flush || !in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_src    <= 1'b0;
      pc_target <= '0;
      flush_cnt <= '0;
    end else begin
      // live already excludes stall, so this also forces 0 on stall
      pc_src <= taken;
      if (taken)
        pc_target <= branch_target;
      if (!stall) begin
        if (taken)
          flush_cnt <= CW'(FLUSH_CYCLES);
        else if (flush_cnt != '0)
          flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // Wrong-path and empty slots become all-zero bubbles
  always_comb begin
    wb_d = '0;
    if (!squash)
      wb_d = {1'b1, wr_reg_in, reg_write_in, mem_to_reg_in};
  end

  wb_delay_line #(
    .DEPTH (WB_DELAY),
    .W     (BW)
  ) u_wb_dly (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .d     (wb_d),
    .q     (wb_q)
  );

  assign wb_valid       = wb_q[BW-1];
  assign wr_reg_out     = wb_q[BW-2:2];
  assign reg_write_out  = wb_q[1];
  assign mem_to_reg_out = wb_q[0];

endmodule

// File: tb/tb_mem_branch_resolve_stage.sv
// Directed bench for mem_branch_resolve_stage.
// Two instances: WB_DELAY=1 (vector table) and WB_DELAY=3.
module tb_mem_branch_resolve_stage;

  logic        clk = 1'b0;
  logic        rst, stall, in_valid, zero, alu_neg;
  logic [1:0]  branch_type;
  logic [31:0] branch_target;
  logic [4:0]  wr_reg_in;
  logic        reg_write_in, mem_to_reg_in;

  logic        pc_src1, flush1, wbv1, rw1, m2r1;
  logic [31:0] tgt1;
  logic [4:0]  wr1;
  logic        pc_src3, flush3, wbv3, rw3, m2r3;
  logic [31:0] tgt3;
  logic [4:0]  wr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_branch_resolve_stage #(.WB_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
    .branch_type(branch_type), .zero(zero), .alu_neg(alu_neg),
    .branch_target(branch_target), .wr_reg_in(wr_reg_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .pc_src(pc_src1), .pc_target(tgt1), .flush(flush1),
    .wb_valid(wbv1), .wr_reg_out(wr1), .reg_write_out(rw1),
    .mem_to_reg_out(m2r1)
  );

  mem_branch_resolve_stage #(.WB_DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
    .branch_type(branch_type), .zero(zero), .alu_neg(alu_neg),
    .branch_target(branch_target), .wr_reg_in(wr_reg_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .pc_src(pc_src3), .pc_target(tgt3), .flush(flush3),
    .wb_valid(wbv3), .wr_reg_out(wr3), .reg_write_out(rw3),
    .mem_to_reg_out(m2r3)
  );

  typedef struct {
    logic        v;
    logic [1:0]  bt;
    logic        z;
    logic        n;
    logic [31:0] tgt;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        e_pc;
    logic [31:0] e_tgt;
    logic        e_fl;
    logic        e_wv;
    logic [4:0]  e_wr;
    logic        e_rw;
    logic        e_m2r;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] bt,
                       input logic z, input logic n,
                       input logic [31:0] tgt, input logic [4:0] wr,
                       input logic rw, input logic m2r);
    in_valid      = v;
    branch_type   = bt;
    zero          = z;
    alu_neg       = n;
    branch_target = tgt;
    wr_reg_in     = wr;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rows: inputs, then expected outputs after the capturing edge
    vecs[0]  = '{1, 2'b01, 1, 0, 32'h0040_0020, 5'd5,  1, 0,
                 1, 32'h0040_0020, 1, 1, 5'd5,  1, 0};
    vecs[1]  = '{1, 2'b00, 0, 0, 32'h0, 5'd8,  1, 0,
                 0, 32'h0040_0020, 1, 0, 5'd0,  0, 0};
    vecs[2]  = '{1, 2'b00, 0, 0, 32'h0, 5'd9,  1, 0,
                 0, 32'h0040_0020, 1, 0, 5'd0,  0, 0};
    vecs[3]  = '{1, 2'b00, 0, 0, 32'h0, 5'd10, 1, 0,
                 0, 32'h0040_0020, 0, 0, 5'd0,  0, 0};
    vecs[4]  = '{1, 2'b00, 0, 0, 32'h0, 5'd11, 1, 1,
                 0, 32'h0040_0020, 0, 1, 5'd11, 1, 1};
    vecs[5]  = '{1, 2'b10, 1, 0, 32'h0000_0aaa, 5'd12, 1, 0,
                 0, 32'h0040_0020, 0, 1, 5'd12, 1, 0};
    vecs[6]  = '{1, 2'b11, 0, 0, 32'h0000_0bbb, 5'd13, 0, 1,
                 0, 32'h0040_0020, 0, 1, 5'd13, 0, 1};
    vecs[7]  = '{0, 2'b01, 1, 0, 32'h0000_0ccc, 5'd14, 1, 0,
                 0, 32'h0040_0020, 0, 0, 5'd0,  0, 0};
    vecs[8]  = '{1, 2'b11, 0, 1, 32'h1000_0004, 5'd15, 1, 0,
                 1, 32'h1000_0004, 1, 1, 5'd15, 1, 0};
    vecs[9]  = '{1, 2'b01, 1, 0, 32'h2222_0000, 5'd16, 1, 0,
                 0, 32'h1000_0004, 1, 0, 5'd0,  0, 0};
    vecs[10] = '{1, 2'b10, 0, 0, 32'h0000_3333, 5'd17, 1, 0,
                 0, 32'h1000_0004, 1, 0, 5'd0,  0, 0};
    vecs[11] = '{0, 2'b00, 0, 0, 32'h0, 5'd0, 0, 0,
                 0, 32'h1000_0004, 0, 0, 5'd0,  0, 0};
    vecs[12] = '{1, 2'b10, 0, 0, 32'h0000_0100, 5'd18, 1, 0,
                 1, 32'h0000_0100, 1, 1, 5'd18, 1, 0};

    // reset while stalled, with live branch inputs present
    @(negedge clk);
    rst   = 1'b1;
    stall = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'hdead_beef, 5'd31, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_pc",   pc_src1, 0);
    chk("rst_tgt",  tgt1,    0);
    chk("rst_fl",   flush1,  0);
    chk("rst_wv",   wbv1,    0);
    chk("rst_wr",   wr1,     0);
    chk("rst_rw",   rw1,     0);
    chk("rst_m2r",  m2r1,    0);
    chk("rst_wv3",  wbv3,    0);

    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].bt, vecs[i].z, vecs[i].n,
            vecs[i].tgt, vecs[i].wr, vecs[i].rw, vecs[i].m2r);
      tick();
      chk($sformatf("r%0d_pc", i),  pc_src1, vecs[i].e_pc);
      chk($sformatf("r%0d_tgt", i), tgt1,    vecs[i].e_tgt);
      chk($sformatf("r%0d_fl", i),  flush1,  vecs[i].e_fl);
      chk($sformatf("r%0d_wv", i),  wbv1,    vecs[i].e_wv);
      chk($sformatf("r%0d_wr", i),  wr1,     vecs[i].e_wr);
      chk($sformatf("r%0d_rw", i),  rw1,     vecs[i].e_rw);
      chk($sformatf("r%0d_m2r", i), m2r1,    vecs[i].e_m2r);
      @(negedge clk);
    end

    // drain the flush from the last row
    idle();
    repeat (4) @(negedge clk);
    chk("drain_fl", flush1, 0);

    // stall for two cycles in the middle of a flush
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0500, 5'd20, 1'b1, 1'b0);
    tick();
    chk("st0_pc", pc_src1, 1);
    chk("st0_fl", flush1,  1);
    chk("st0_wr", wr1,     20);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0600, 5'd21, 1'b1, 1'b1);
      tick();
      chk($sformatf("st%0d_pc", k + 1),  pc_src1, 0);
      chk($sformatf("st%0d_fl", k + 1),  flush1,  1);
      chk($sformatf("st%0d_wv", k + 1),  wbv1,    1);
      chk($sformatf("st%0d_wr", k + 1),  wr1,     20);
      chk($sformatf("st%0d_tgt", k + 1), tgt1,    32'h0000_0500);
    end
    @(negedge clk);
    stall = 1'b0;
    idle();
    tick();
    chk("st3_fl", flush1, 1);
    chk("st3_wv", wbv1,   0);
    @(negedge clk);
    tick();
    chk("st4_fl", flush1, 1);
    @(negedge clk);
    tick();
    chk("st5_fl", flush1, 0);

    // WB_DELAY=3 latency
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 5'd24, 1'b1, 1'b0);
    tick();
    chk("d3_e1_wv", wbv3, 0);
    @(negedge clk);
    idle();
    tick();
    chk("d3_e2_wv", wbv3, 0);
    @(negedge clk);
    tick();
    chk("d3_e3_wv", wbv3, 1);
    chk("d3_e3_wr", wr3,  24);
    chk("d3_e3_rw", rw3,  1);

    // reset in the middle of a flush on the deep instance
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0700, 5'd22, 1'b1, 1'b0);
    tick();
    chk("rf_pc3", pc_src3, 1);
    chk("rf_fl3", flush3,  1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 5'd23, 1'b1, 1'b0);
    tick();
    chk("rf_fl3_r", flush3,  0);
    chk("rf_pc3_r", pc_src3, 0);
    chk("rf_tg3_r", tgt3,    0);
    chk("rf_fl1_r", flush1,  0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rf_wv3_%0d", k), wbv3, 0);
      chk($sformatf("rf_rw3_%0d", k), rw3,  0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
